commit_monitor: RTL

Parametrised commit/trap monitor that sits between the core's writeback stage and the difftest DPI modules (DifftestInstrCommit, DifftestTrapEvent). It registers up to COMMIT_WIDTH retiring instructions per cycle and detects the `0x6b` good-trap opcode on any channel. It keeps 64-bit cycle and instruction counters and freezes all state once the run ends. It replaces ad-hoc single-channel commit registers in core top levels and supports multi-issue cores.

---
 rtl/commit_monitor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/commit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : commit_monitor
// Purpose  : Registers up to COMMIT_WIDTH retiring instructions per cycle,
//            detects the 0x6b good-trap opcode and keeps cycle/instr counters.
//            Optional watchdog enabled by defining COMMIT_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module commit_monitor #(
  parameter int XLEN         = 64,
  parameter int COMMIT_WIDTH = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [COMMIT_WIDTH-1:0]      in_valid,
  input  logic [COMMIT_WIDTH*XLEN-1:0] in_pc,
  input  logic [COMMIT_WIDTH*32-1:0]   in_inst,
  input  logic [COMMIT_WIDTH-1:0]      in_wen,
  input  logic [COMMIT_WIDTH*5-1:0]    in_wdest,
  input  logic [COMMIT_WIDTH*XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0]              in_a0,
  output logic [COMMIT_WIDTH-1:0]      cmt_valid,
  output logic [COMMIT_WIDTH*XLEN-1:0] cmt_pc,
  output logic [COMMIT_WIDTH*32-1:0]   cmt_inst,
  output logic [COMMIT_WIDTH*XLEN-1:0] cmt_wdata,
  output logic [COMMIT_WIDTH-1:0]      cmt_wen,
  output logic [COMMIT_WIDTH*8-1:0]    cmt_wdest,
  output logic                         trap,
  output logic [7:0]                   trap_code,
  output logic [XLEN-1:0]              trap_pc,
  output logic [63:0]                  cycle_cnt,
  output logic [63:0]                  instr_cnt,
  output logic                         timeout
);

  typedef enum logic [0:0] {
    c_run  = 1'b0,
    c_halt = 1'b1
  } state_t;

  state_t                      r_state;
  logic [COMMIT_WIDTH-1:0]      r_cmt_valid;
  logic [COMMIT_WIDTH-1:0]      r_cmt_wen;
  logic [COMMIT_WIDTH*XLEN-1:0] r_cmt_pc;
  logic [COMMIT_WIDTH*32-1:0]   r_cmt_inst;
  logic [COMMIT_WIDTH*XLEN-1:0] r_cmt_wdata;
  logic [COMMIT_WIDTH*8-1:0]    r_cmt_wdest;
  logic                         r_trap;
  logic [7:0]                   r_trap_code;
  logic [XLEN-1:0]              r_trap_pc;
  logic [63:0]                  r_cycle_cnt;
  logic [63:0]                  r_instr_cnt;

  logic [COMMIT_WIDTH-1:0]      w_eff_valid;
  logic [COMMIT_WIDTH-1:0]      w_wen;
  logic [COMMIT_WIDTH*8-1:0]    w_wdest;
  logic                         w_trap_hit;
  logic [XLEN-1:0]              w_trap_pc;
  logic [3:0]                   w_commit_cnt;
  logic [XLEN-1:0]              w_last_pc;

  // Upper a0 bits never reach an output; TIMEOUT is idle without the watchdog
  wire w_unused = &{1'b0, in_a0[XLEN-1:8], 32'(TIMEOUT)};

  // Walk oldest to youngest; everything after the first trap is squashed
  always_comb begin
    w_eff_valid  = '0;
    w_trap_hit   = 1'b0;
    w_trap_pc    = '0;
    w_commit_cnt = 4'd0;
    w_last_pc    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!w_trap_hit && in_valid[i]) begin
        w_eff_valid[i] = 1'b1;
        w_commit_cnt   = w_commit_cnt + 4'd1;
        w_last_pc      = in_pc[i*XLEN +: XLEN];
        if (in_inst[i*32 +: 7] == 7'h6b) begin
          w_trap_hit = 1'b1;
          w_trap_pc  = in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_chan
    assign w_wen[gi]            = in_wen[gi] & w_eff_valid[gi] & (in_wdest[gi*5 +: 5] != 5'd0);
    assign w_wdest[gi*8 +: 8]   = {3'b000, in_wdest[gi*5 +: 5]};
  end

`ifdef COMMIT_WATCHDOG_EN
  logic [31:0]     r_wd_cnt;
  logic            r_timeout;
  logic [XLEN-1:0] r_last_pc;
  logic            w_wd_expire;

  assign w_wd_expire = (w_commit_cnt == 4'd0) && (r_wd_cnt == 32'(TIMEOUT - 1));
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= c_run;
      r_cmt_valid <= '0;
      r_cmt_wen   <= '0;
      r_cmt_pc    <= '0;
      r_cmt_inst  <= '0;
      r_cmt_wdata <= '0;
      r_cmt_wdest <= '0;
      r_trap      <= 1'b0;
      r_trap_code <= 8'd0;
      r_trap_pc   <= '0;
      r_cycle_cnt <= 64'd0;
      r_instr_cnt <= 64'd0;
`ifdef COMMIT_WATCHDOG_EN
      r_wd_cnt    <= 32'd0;
      r_timeout   <= 1'b0;
      r_last_pc   <= '0;
`endif
    end else begin
      case (r_state)
        c_run: begin
          r_cmt_valid <= w_eff_valid;
          r_cmt_wen   <= w_wen;
          r_cmt_pc    <= in_pc;
          r_cmt_inst  <= in_inst;
          r_cmt_wdata <= in_wdata;
          r_cmt_wdest <= w_wdest;
          r_cycle_cnt <= r_cycle_cnt + 64'd1;
          r_instr_cnt <= r_instr_cnt + 64'(w_commit_cnt);
          if (w_trap_hit) begin
            r_trap      <= 1'b1;
            r_trap_code <= in_a0[7:0];
            r_trap_pc   <= w_trap_pc;
            r_state     <= c_halt;
          end
`ifdef COMMIT_WATCHDOG_EN
          else if (w_wd_expire) begin
            r_timeout   <= 1'b1;
            r_trap      <= 1'b1;
            r_trap_code <= 8'hFF;
            r_trap_pc   <= r_last_pc;
            r_state     <= c_halt;
          end
          if (w_commit_cnt != 4'd0) begin
            r_wd_cnt  <= 32'd0;
            r_last_pc <= w_last_pc;
          end else begin
            r_wd_cnt  <= r_wd_cnt + 32'd1;
          end
`endif
        end
        c_halt: begin
          r_cmt_valid <= '0;
          r_cmt_wen   <= '0;
        end
        default: r_state <= c_halt;
      endcase
    end
  end

  assign cmt_valid = r_cmt_valid;
  assign cmt_wen   = r_cmt_wen;
  assign cmt_pc    = r_cmt_pc;
  assign cmt_inst  = r_cmt_inst;
  assign cmt_wdata = r_cmt_wdata;
  assign cmt_wdest = r_cmt_wdest;
  assign trap      = r_trap;
  assign trap_code = r_trap_code;
  assign trap_pc   = r_trap_pc;
  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire
